iob_eth_rx: RTL and testbench



---
 rtl/iob_eth_rx_pkg.sv | 31 +++
 rtl/iob_eth_crc.sv | 21 ++
 rtl/iob_eth_rx.sv | 127 ++++++++++++
 tb/tb_iob_eth_rx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_rx_pkg.sv
// Shared constants, state type and CRC-32 byte step for the MII receive path.
package iob_eth_rx_pkg;

    localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
    localparam logic [3:0]  SFD_NIB       = 4'hD;
    // 0x04C11DB7 bit-reversed, for the LSB-first (reflected) shift register
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    // Register value left after clocking a frame plus its own FCS through
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA_LO,
        ST_DATA_HI,
        ST_CHECK,
        ST_DONE,
        ST_DROP
    } rx_state_t;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            c = (c[0] ^ b[i]) ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/iob_eth_crc.sv
// Byte-wide CRC-32 accumulator: start reloads the seed, data_en folds in one byte.
module iob_eth_crc
    import iob_eth_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        data_en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            crc <= CRC_INIT;
        end else if (data_en) begin
            crc <= crc32_byte(crc, data);
        end
    end

endmodule

// File: rtl/iob_eth_rx.sv
// MII receive engine: preamble/SFD detect, nibble-to-byte assembly, buffer writes,
// FCS residue check and a held frame-received status released by rcv_ack.
module iob_eth_rx
    import iob_eth_rx_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 1518
) (
    input  logic        RX_CLK,
    input  logic        rst,
    input  logic        RX_DV,
    input  logic        RX_ER,
    input  logic [3:0]  RX_DATA,
    output logic        wr,
    output logic [10:0] addr,
    output logic [7:0]  data,
    output logic        received,
    output logic [10:0] nbytes,
    output logic        crc_ok,
    input  logic        rcv_ack
);

    rx_state_t   state, state_nxt;
    logic [3:0]  lo;
    logic [10:0] cnt;
    logic [31:0] crc;
    logic        sfd, lo_en, byte_en, report, release_st;

    // The CRC follows the registered write strobe, so it settles one edge after
    // the last byte is written; the CHECK state absorbs that edge.
    iob_eth_crc u_crc (
        .clk     (RX_CLK),
        .rst     (rst),
        .start   (sfd),
        .data_en (wr),
        .data    (data),
        .crc     (crc)
    );

    always_ff @(posedge RX_CLK) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        sfd        = 1'b0;
        lo_en      = 1'b0;
        byte_en    = 1'b0;
        report     = 1'b0;
        release_st = 1'b0;
        case (state)
            ST_IDLE: begin
                if (RX_DV) begin
                    state_nxt = (RX_DATA == PREAMBLE_NIB && !RX_ER) ? ST_PREAMBLE : ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (!RX_DV)                       state_nxt = ST_IDLE;
                else if (RX_ER)                   state_nxt = ST_DROP;
                else if (RX_DATA == SFD_NIB) begin
                    sfd       = 1'b1;
                    state_nxt = ST_DATA_LO;
                end
                else if (RX_DATA != PREAMBLE_NIB) state_nxt = ST_DROP;
            end
            ST_DATA_LO: begin
                if (!RX_DV)      state_nxt = ST_CHECK;
                else if (RX_ER)  state_nxt = ST_DROP;
                else begin
                    lo_en     = 1'b1;
                    state_nxt = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (!RX_DV)                                state_nxt = ST_CHECK;
                else if (RX_ER || cnt == 11'(MAX_BYTES))   state_nxt = ST_DROP;
                else begin
                    byte_en   = 1'b1;
                    state_nxt = ST_DATA_LO;
                end
            end
            ST_CHECK: begin
                report    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (rcv_ack) begin
                    release_st = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!RX_DV) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            wr       <= 1'b0;
            addr     <= '0;
            data     <= '0;
            received <= 1'b0;
            nbytes   <= '0;
            crc_ok   <= 1'b0;
            cnt      <= '0;
            lo       <= '0;
        end else begin
            wr <= byte_en;
            if (sfd)   cnt <= '0;
            if (lo_en) lo  <= RX_DATA;
            if (byte_en) begin
                data <= {RX_DATA, lo};
                addr <= cnt;
                cnt  <= cnt + 11'd1;
            end
            if (report) begin
                received <= 1'b1;
                nbytes   <= cnt;
                crc_ok   <= (cnt >= 11'd4) && (crc == CRC_RESIDUE);
            end
            if (release_st) received <= 1'b0;
        end
    end

endmodule

// File: tb/tb_iob_eth_rx.sv
// Directed-random bench for iob_eth_rx: frames with software-computed FCS, checked
// against expected byte streams and a byte-level CRC reference.
module tb_iob_eth_rx;

    logic        clk = 1'b0;
    logic        rst, dv, er, ack;
    logic [3:0]  rxd;
    logic        wr, received, crc_ok;
    logic [10:0] addr, nbytes;
    logic [7:0]  data;
    logic        s_wr, s_received, s_crc_ok;
    logic [10:0] s_addr, s_nbytes;
    logic [7:0]  s_data;

    int checks   = 0;
    int failures = 0;

    logic [18:0] wq[$];
    int          s_nwr = 0;
    logic [10:0] s_last = '0;

    always #5 clk = ~clk;

    iob_eth_rx #(.MAX_BYTES(1518)) dut (
        .RX_CLK(clk), .rst(rst), .RX_DV(dv), .RX_ER(er), .RX_DATA(rxd),
        .wr(wr), .addr(addr), .data(data), .received(received),
        .nbytes(nbytes), .crc_ok(crc_ok), .rcv_ack(ack)
    );

    iob_eth_rx #(.MAX_BYTES(64)) dut_small (
        .RX_CLK(clk), .rst(rst), .RX_DV(dv), .RX_ER(er), .RX_DATA(rxd),
        .wr(s_wr), .addr(s_addr), .data(s_data), .received(s_received),
        .nbytes(s_nbytes), .crc_ok(s_crc_ok), .rcv_ack(ack)
    );

    always @(negedge clk) begin
        if (wr) wq.push_back({addr, data});
        if (s_wr) begin
            s_nwr++;
            s_last = s_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [7:0] b[$], input int n);
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    function automatic logic ref_crc_ok(input logic [7:0] b[$]);
        int n;
        n = b.size();
        if (n < 4) return 1'b0;
        return ref_crc(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]};
    endfunction

    task automatic make_frame(input int len, output logic [7:0] f[$]);
        logic [31:0] c;
        f = {};
        for (int i = 0; i < len - 4; i++) f.push_back(8'($urandom));
        c = ref_crc(f, len - 4);
        f.push_back(c[7:0]);
        f.push_back(c[15:8]);
        f.push_back(c[23:16]);
        f.push_back(c[31:24]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr"}, 32'(wr), 32'd0);
        chk({tag, "_addr"}, 32'(addr), 32'd0);
        chk({tag, "_data"}, 32'(data), 32'd0);
        chk({tag, "_received"}, 32'(received), 32'd0);
        chk({tag, "_nbytes"}, 32'(nbytes), 32'd0);
        chk({tag, "_crc_ok"}, 32'(crc_ok), 32'd0);
    endtask

    // Drives preamble, SFD, bytes low nibble first, optional dribble nibble; leaves RX_DV low.
    task automatic send(input logic [7:0] f[$], input int npre, input bit dribble,
                        input int er_at, input int rst_at);
        for (int i = 0; i < npre; i++) begin
            dv = 1'b1; er = 1'b0; rxd = 4'h5;
            @(negedge clk);
        end
        rxd = 4'hD;
        @(negedge clk);
        for (int i = 0; i < f.size(); i++) begin
            if (i == rst_at) rst = 1'b1;
            rxd = f[i][3:0];
            er  = (i == er_at);
            @(negedge clk);
            if (i == rst_at) begin
                rst = 1'b0;
                chk_reset_outputs("midrst");
            end
            er  = 1'b0;
            rxd = f[i][7:4];
            @(negedge clk);
        end
        if (dribble) begin
            rxd = 4'hA;
            @(negedge clk);
        end
        dv = 1'b0; er = 1'b0; rxd = 4'h0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic chk_writes(input string tag, input logic [7:0] f[$], input int base);
        int n;
        n = wq.size() - base;
        chk({tag, "_nwr"}, 32'(n), 32'(f.size()));
        for (int i = 0; i < n && i < f.size(); i++) begin
            chk({tag, "_addr"}, 32'(wq[base+i][18:8]), 32'(i));
            chk({tag, "_data"}, 32'(wq[base+i][7:0]), 32'(f[i]));
        end
    endtask

    task automatic chk_status(input string tag, input logic [7:0] f[$]);
        chk({tag, "_received"}, 32'(received), 32'd1);
        chk({tag, "_nbytes"}, 32'(nbytes), 32'(f.size()));
        chk({tag, "_crc_ok"}, 32'(crc_ok), 32'(ref_crc_ok(f)));
    endtask

    initial begin
        logic [7:0] f[$], g[$], h[$];
        int base, sbase;

        rst = 1'b1; dv = 1'b0; er = 1'b0; rxd = 4'h0; ack = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Good 64-byte frame, long preamble
        make_frame(64, f);
        base = wq.size(); sbase = s_nwr;
        send(f, 15, 1'b0, -1, -1);
        settle();
        chk_writes("good64", f, base);
        chk_status("good64", f);
        chk("good64_crc_expected", 32'(crc_ok), 32'd1);
        chk("good64_small_received", 32'(s_received), 32'd1);
        chk("good64_small_nbytes", 32'(s_nbytes), 32'd64);
        do_ack();
        chk("ack_release", 32'(received), 32'd0);

        // Single payload bit flipped
        g = f;
        g[30] = g[30] ^ 8'h08;
        send(g, 7, 1'b0, -1, -1);
        settle();
        chk_status("bitflip", g);
        chk("bitflip_crc_bad", 32'(crc_ok), 32'd0);
        do_ack();

        // RX_ER on byte 20 aborts the frame
        make_frame(90, f);
        base = wq.size();
        send(f, 7, 1'b0, 20, -1);
        settle();
        chk("rxer_nwr", 32'(wq.size() - base), 32'd20);
        chk("rxer_received", 32'(received), 32'd0);
        make_frame(60 + int'($urandom_range(0, 60)), f);
        base = wq.size();
        send(f, 7, 1'b0, -1, -1);
        settle();
        chk_writes("after_rxer", f, base);
        chk_status("after_rxer", f);
        do_ack();

        // Back-to-back without ack: second frame ignored
        make_frame(80, f);
        send(f, 7, 1'b0, -1, -1);
        settle();
        make_frame(70, g);
        base = wq.size();
        send(g, 7, 1'b0, -1, -1);
        settle();
        chk("b2b_second_nwr", 32'(wq.size() - base), 32'd0);
        chk_status("b2b_held", f);
        do_ack();
        // Third frame starts the cycle right after the ack edge
        make_frame(70, h);
        base = wq.size();
        send(h, 7, 1'b0, -1, -1);
        settle();
        chk_writes("third", h, base);
        chk_status("third", h);
        do_ack();

        // Overflow on the MAX_BYTES=64 instance
        make_frame(65, f);
        sbase = s_nwr;
        send(f, 7, 1'b0, -1, -1);
        settle();
        chk("ovf_small_nwr", 32'(s_nwr - sbase), 32'd64);
        chk("ovf_small_last_addr", 32'(s_last), 32'd63);
        chk("ovf_small_received", 32'(s_received), 32'd0);
        chk_status("ovf_main", f);
        do_ack();

        // Trailing dribble nibble is discarded
        make_frame(64, f);
        base = wq.size();
        send(f, 7, 1'b1, -1, -1);
        settle();
        chk_writes("dribble", f, base);
        chk_status("dribble", f);
        chk("dribble_small_received", 32'(s_received), 32'd1);
        chk("dribble_small_nbytes", 32'(s_nbytes), 32'd64);
        chk("dribble_small_crc_ok", 32'(s_crc_ok), 32'd1);
        do_ack();

        // Reset mid-payload; rest of the frame must be dropped
        make_frame(100, f);
        f[30] = 8'h00;
        base = wq.size();
        send(f, 7, 1'b0, -1, 30);
        settle();
        chk("midrst_nwr", 32'(wq.size() - base), 32'd30);
        chk("midrst_received", 32'(received), 32'd0);
        make_frame(64 + int'($urandom_range(0, 100)), f);
        base = wq.size();
        send(f, 7, 1'b0, -1, -1);
        settle();
        chk_writes("post_rst", f, base);
        chk_status("post_rst", f);
        do_ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
